// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding bus read at a time, results queued for decode.
// Misaligned PCs and bus errors are turned into faulting NOP entries.
module instr_fetch #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] word_mem  [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic        fault_mem [FIFO_DEPTH];

    logic        fifo_empty, outstanding, space_avail, pc_aligned;
    logic        start_fetch, take_misaligned;
    logic        push, pop;
    logic [31:0] push_word, push_pc;
    logic        push_fault;

    // A slot is reserved while a fetch is in REQ/WAIT, so a response can never overflow.
    assign fifo_empty      = (count_q == '0);
    assign outstanding     = (state_q == REQ) || (state_q == WAIT);
    assign space_avail     = (count_q + CW'(outstanding)) < DEPTH_C;
    assign pc_aligned      = (pc_in[1:0] == 2'b00);
    assign start_fetch     = (state_q == IDLE) && !flush && space_avail && pc_aligned;
    assign take_misaligned = (state_q == IDLE) && !flush && space_avail && !pc_aligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_fetch) state_d = REQ;
            REQ: begin
                if (imem_gnt) state_d = flush ? DROP : WAIT;
                else if (flush) state_d = IDLE;
            end
            WAIT: begin
                if (imem_rvalid) state_d = IDLE;
                else if (flush) state_d = DROP;
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req   = rst_n && (state_q == REQ);
        imem_addr  = req_addr_q;
        pc_advance = rst_n && !flush && (take_misaligned || ((state_q == REQ) && imem_gnt));
        push       = 1'b0;
        push_word  = NOP_INSTR;
        push_pc    = pc_in;
        push_fault = 1'b1;
        if (take_misaligned) begin
            push = 1'b1;
        end else if ((state_q == WAIT) && imem_rvalid && !flush) begin
            push       = 1'b1;
            push_word  = imem_err ? NOP_INSTR : imem_rdata;
            push_pc    = req_addr_q;
            push_fault = imem_err;
        end
    end

    always_comb begin
        instr_valid = rst_n && !fifo_empty;
        instr_out   = NOP_INSTR;
        instr_pc    = '0;
        instr_fault = 1'b0;
        if (instr_valid) begin
            instr_out   = word_mem[rd_ptr_q];
            instr_pc    = pc_mem[rd_ptr_q];
            instr_fault = fault_mem[rd_ptr_q];
        end
    end

    assign pop = instr_valid && instr_ready;

    always_comb begin
        req_addr_d = start_fetch ? pc_in : req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            word_mem[wr_ptr_q]  <= push_word;
            pc_mem[wr_ptr_q]    <= push_pc;
            fault_mem[wr_ptr_q] <= push_fault;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked against a
// queue-based model of fetched entries, a PC-stage model and a one-deep memory model.
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, flush, imem_gnt, imem_rvalid, imem_err, instr_ready;
    logic [31:0] pc_in, imem_rdata;
    logic        pc_advance, imem_req, instr_valid, instr_fault;
    logic [31:0] imem_addr, instr_out, instr_pc;

    instr_fetch #(.FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    entry_t      fifo_m[$];
    logic [31:0] pend_m[$];
    int          checks = 0, errors = 0;

    logic [31:0] pc_model = 32'h0, flush_target = 32'h0;
    bit          mem_busy = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_lat = 0, lat_cfg = 0, err_mode = 0;
    bit          mis_en = 1'b0;
    int          grant_cnt = 0, push_cnt = 0, pop_cnt = 0, adv_cnt = 0;
    logic [31:0] last_grant_addr = 32'h0;
    logic        s_req, s_adv, s_valid, s_fault;
    logic [31:0] s_addr, s_out, s_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        if (a == 32'h20)  return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after negedge, sample just after, then advance all models
    // to what must hold after the coming rising edge.
    task automatic cycle(input bit fl, input bit rdy, input bit gnt_en, input bit rst, input bit spur);
        bit deliver;
        entry_t e;
        @(negedge clk);
        rst_n       = !rst;
        flush       = fl;
        instr_ready = rdy;
        pc_in       = pc_model;
        imem_gnt    = gnt_en && !mem_busy;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        imem_err    = 1'($urandom_range(0, 1));
        deliver     = 1'b0;
        if (mem_busy && mem_lat == 0) begin
            deliver     = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(mem_addr);
            imem_err    = mem_err;
        end else if (spur && !mem_busy) begin
            imem_rvalid = 1'b1;
        end
        #1;
        s_req = imem_req; s_adv = pc_advance; s_valid = instr_valid; s_fault = instr_fault;
        s_addr = imem_addr; s_out = instr_out; s_pc = instr_pc;
        if (s_adv === 1'b1) adv_cnt++;

        if (rst) begin
            chk("rst_req", 32'(s_req), 32'd0);
            chk("rst_adv", 32'(s_adv), 32'd0);
            chk("rst_valid", 32'(s_valid), 32'd0);
            chk("rst_out", s_out, NOP);
            chk("rst_pc", s_pc, 32'h0);
            chk("rst_fault", 32'(s_fault), 32'd0);
            fifo_m.delete();
            pend_m.delete();
        end else begin
            chk("valid", 32'(s_valid), 32'(fifo_m.size() != 0));
            if (fifo_m.size() != 0) begin
                chk("head_word", s_out, fifo_m[0].word);
                chk("head_pc", s_pc, fifo_m[0].pc);
                chk("head_fault", 32'(s_fault), 32'(fifo_m[0].fault));
            end else begin
                chk("empty_word", s_out, NOP);
                chk("empty_pc", s_pc, 32'h0);
                chk("empty_fault", 32'(s_fault), 32'd0);
            end
            if (s_req === 1'b1) begin
                chk("req_addr", s_addr, pc_model);
                chk("req_space", 32'(fifo_m.size() < DEPTH), 32'd1);
                chk("req_adv", 32'(s_adv), 32'(imem_gnt && !fl));
            end
            if (pc_model[1:0] != 2'b00) chk("misalign_noreq", 32'(s_req), 32'd0);
            if (fl) chk("flush_noadv", 32'(s_adv), 32'd0);

            if (fl) begin
                fifo_m.delete();
                pend_m.delete();
            end else begin
                if (fifo_m.size() != 0 && rdy) begin
                    void'(fifo_m.pop_front());
                    pop_cnt++;
                end
                if (deliver && pend_m.size() != 0) begin
                    e.word  = mem_err ? NOP : data_of(mem_addr);
                    e.pc    = pend_m.pop_front();
                    e.fault = mem_err;
                    fifo_m.push_back(e);
                    push_cnt++;
                end
                if (s_adv === 1'b1) begin
                    if (pc_model[1:0] != 2'b00) begin
                        e.word = NOP; e.pc = pc_model; e.fault = 1'b1;
                        fifo_m.push_back(e);
                        push_cnt++;
                    end else begin
                        pend_m.push_back(pc_model);
                    end
                end
            end
        end

        if (deliver) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (!rst && s_req === 1'b1 && imem_gnt) begin
            mem_busy        = 1'b1;
            mem_addr        = s_addr;
            mem_err         = (err_mode == 2) ? ($urandom_range(0, 7) == 0) : (err_mode == 1);
            mem_lat         = (lat_cfg < 0) ? int'($urandom_range(0, 2)) : lat_cfg;
            grant_cnt++;
            last_grant_addr = s_addr;
        end

        if (!rst) begin
            if (fl) pc_model = flush_target;
            else if (s_adv === 1'b1) begin
                if (pc_model[1:0] != 2'b00) pc_model = {pc_model[31:2], 2'b00} + 32'd4;
                else if (mis_en && $urandom_range(0, 7) == 0) pc_model = pc_model + 32'd6;
                else pc_model = pc_model + 32'd4;
            end
        end
    endtask

    task automatic restart(input logic [31:0] start_pc);
        for (int i = 0; i < 8 && mem_busy; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pc_model  = start_pc;
        grant_cnt = 0; push_cnt = 0; pop_cnt = 0; adv_cnt = 0;
    endtask

    initial begin
        bit r_fl, r_rdy, r_gnt, r_rst, r_spur;
        rst_n = 1'b0; flush = 1'b0; pc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; imem_err = 1'b0; instr_ready = 1'b0;

        // Single fetch, immediate grant, response next cycle
        restart(32'h100);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("basic_req", 32'(s_req), 32'd1);
        chk("basic_addr", s_addr, 32'h100);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("basic_adv_cnt", 32'(adv_cnt), 32'd1);
        chk("basic_valid", 32'(s_valid), 32'd1);
        chk("basic_out", s_out, 32'h00500093);
        chk("basic_pc", s_pc, 32'h100);

        // Backpressure: two entries fill the buffer, third fetch waits for a pop
        restart(32'h0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 0);
        chk("bp_grants", 32'(grant_cnt), 32'd2);
        chk("bp_noreq", 32'(s_req), 32'd0);
        chk("bp_head", s_pc, 32'h0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        chk("bp_resume_cnt", 32'(grant_cnt), 32'd3);
        chk("bp_resume_addr", last_grant_addr, 32'h8);

        // Flush while waiting for the response
        restart(32'h20);
        lat_cfg = 2;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        flush_target = 32'h200;
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        chk("flush_valid", 32'(s_valid), 32'd0);
        chk("flush_newreq", 32'(s_req), 32'd1);
        chk("flush_newaddr", s_addr, 32'h200);
        lat_cfg = 0;

        // Misaligned PC becomes a faulting NOP without a bus request
        restart(32'h102);
        cycle(0, 0, 1, 0, 0);
        chk("mis_req", 32'(s_req), 32'd0);
        chk("mis_adv", 32'(s_adv), 32'd1);
        cycle(0, 0, 0, 0, 0);
        chk("mis_fault", 32'(s_fault), 32'd1);
        chk("mis_out", s_out, 32'h00000013);
        chk("mis_pc", s_pc, 32'h102);

        // Bus error
        restart(32'h40);
        err_mode = 1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("err_fault", 32'(s_fault), 32'd1);
        chk("err_out", s_out, NOP);
        chk("err_pc", s_pc, 32'h40);
        err_mode = 0;

        // Reset while waiting; the late response must be ignored
        restart(32'h60);
        lat_cfg = 1;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        chk("rstwait_valid0", 32'(s_valid), 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("rstwait_valid1", 32'(s_valid), 32'd0);
        lat_cfg = 0;

        // Throughput with zero-latency memory and no backpressure
        restart(32'h1000);
        for (int i = 0; i < 30; i++) cycle(0, 1, 1, 0, 0);
        chk("throughput", 32'(push_cnt), 32'd10);

        // Random traffic
        restart(32'h2000);
        lat_cfg = -1; err_mode = 2; mis_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            r_fl   = ($urandom_range(0, 19) == 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_gnt  = ($urandom_range(0, 3) != 0);
            r_rst  = ($urandom_range(0, 399) == 0);
            r_spur = ($urandom_range(0, 15) == 0);
            flush_target = $urandom & 32'h0000FFFC;
            cycle(r_fl, r_rdy, r_gnt, r_rst, r_spur);
        end
        chk("liveness", 32'(pop_cnt >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
